// File: rtl/pr_request_queue_pkg.sv
// Shared types and default sizing for the partial-reconfiguration request queue.
// The grid and OU counts mirror the RCA configuration the queue is built against.
package pr_request_queue_pkg;

  localparam int GRID_NUM_COLS     = 4;
  localparam int GRID_NUM_ROWS     = 2;
  localparam int RCA_NUM_SLOTS     = GRID_NUM_COLS * GRID_NUM_ROWS;
  localparam int RCA_NUM_OUS       = 4;
  localparam int PR_QUEUE_DEPTH    = 4;
  localparam int PR_TIMEOUT_CYCLES = 65536;

  localparam int PR_SLOT_W = $clog2(RCA_NUM_SLOTS);
  localparam int PR_OU_W   = $clog2(RCA_NUM_OUS);

  // Request as issued by the RCA/PR issue path; slot occupies the upper bits.
  typedef struct packed {
    logic [PR_SLOT_W-1:0] grid_slot;
    logic [PR_OU_W-1:0]   ou_id;
  } pr_queue_inputs_t;

  typedef enum logic [1:0] {
    PRQ_IDLE,
    PRQ_REQ,
    PRQ_WAIT
  } pr_queue_state_t;

  function automatic logic [PR_SLOT_W+PR_OU_W-1:0] pack_request(
    input logic [PR_SLOT_W-1:0] slot,
    input logic [PR_OU_W-1:0]   ou
  );
    return {slot, ou};
  endfunction

endpackage

// File: rtl/pr_request_fifo.sv
// Power-of-two circular FIFO that also exposes every slot with a live flag,
// so the queue can compare an incoming request against all pending ones.
module pr_request_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 5,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DEPTH-1:0]       valid_o,
  output logic [DEPTH*WIDTH-1:0] entries_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign head_o  = mem_q[head_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem_q[tail_q] <= data_i;
        tail_q        <= tail_q + 1'b1;
      end
      if (doPop) begin
        head_q <= head_q + 1'b1;
      end
      if (doPush && !doPop) begin
        count_q <= count_q + 1'b1;
      end else if (doPop && !doPush) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // A slot is live when its distance ahead of the head is below the fill count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset                         = PTR_W'(i) - head_q;
    assign valid_o[i]                     = ({1'b0, offset} < count_q);
    assign entries_o[i*WIDTH +: WIDTH]    = mem_q[i];
  end

endmodule

// File: rtl/pr_request_queue.sv
// Buffers PR requests, drops redundant ones, serialises the rest to the ICAP
// wrapper and tracks which OU each grid slot currently holds.
module pr_request_queue
  import pr_request_queue_pkg::*;
#(
  parameter  int QUEUE_DEPTH    = PR_QUEUE_DEPTH,
  parameter  int NUM_SLOTS      = RCA_NUM_SLOTS,
  parameter  int NUM_OUS        = RCA_NUM_OUS,
  parameter  int TIMEOUT_CYCLES = PR_TIMEOUT_CYCLES,
  localparam int SLOT_W         = $clog2(NUM_SLOTS),
  localparam int OU_W           = $clog2(NUM_OUS),
  localparam int REQ_W          = SLOT_W + OU_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [REQ_W-1:0]            req_i,
  output logic                        pr_req_valid_o,
  input  logic                        pr_req_ready_i,
  output logic [SLOT_W-1:0]           pr_grid_slot_o,
  output logic [OU_W-1:0]             pr_ou_id_o,
  input  logic                        pr_done_i,
  input  logic                        pr_error_i,
  output logic [NUM_SLOTS-1:0]        slot_busy_o,
  output logic [NUM_SLOTS-1:0]        slot_loaded_o,
  output logic [NUM_SLOTS*OU_W-1:0]   slot_ou_o,
  output logic                        queue_empty_o,
  output logic                        err_sticky_o,
  input  logic                        err_clear_i
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  pr_queue_state_t             state_q;
  logic                        prReqValid_q;
  logic [SLOT_W-1:0]           inflightSlot_q;
  logic [OU_W-1:0]             inflightOu_q;
  logic [TMR_W-1:0]            timer_q;
  logic [NUM_SLOTS-1:0]        slotLoaded_q;
  logic [OU_W-1:0]             slotOu_q [NUM_SLOTS];
  logic                        errSticky_q;

  logic                        fifoPush;
  logic                        fifoPop;
  logic                        fifoFull;
  logic                        fifoEmpty;
  logic [REQ_W-1:0]            fifoHead;
  logic [QUEUE_DEPTH-1:0]      fifoValid;
  logic [QUEUE_DEPTH*REQ_W-1:0] fifoEntries;

  logic [SLOT_W-1:0]           reqSlot;
  logic [OU_W-1:0]             reqOu;
  logic [SLOT_W-1:0]           headSlot;
  logic [OU_W-1:0]             headOu;
  logic [NUM_SLOTS-1:0]        slotBusy;
  logic                        fifoHit;
  logic                        inflightHit;
  logic                        loadedHit;
  logic                        isDuplicate;
  logic                        waitFail;

  assign reqSlot  = req_i[REQ_W-1:OU_W];
  assign reqOu    = req_i[OU_W-1:0];
  assign headSlot = fifoHead[REQ_W-1:OU_W];
  assign headOu   = fifoHead[OU_W-1:0];

  pr_request_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (fifoPush),
    .pop_i     (fifoPop),
    .data_i    (req_i),
    .head_o    (fifoHead),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty),
    .valid_o   (fifoValid),
    .entries_o (fifoEntries)
  );

  // Busy slots and queue hits come from every live FIFO entry plus the in-flight one.
  always_comb begin
    slotBusy = '0;
    fifoHit  = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (fifoValid[i]) begin
        if (fifoEntries[i*REQ_W +: REQ_W] == req_i) begin
          fifoHit = 1'b1;
        end
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (fifoEntries[i*REQ_W+OU_W +: SLOT_W] == SLOT_W'(s)) begin
            slotBusy[s] = 1'b1;
          end
        end
      end
    end
    if (state_q != PRQ_IDLE) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (inflightSlot_q == SLOT_W'(s)) begin
          slotBusy[s] = 1'b1;
        end
      end
    end
  end

  assign inflightHit = (state_q != PRQ_IDLE) && ({inflightSlot_q, inflightOu_q} == req_i);
  assign loadedHit   = slotLoaded_q[reqSlot] && (slotOu_q[reqSlot] == reqOu) && !slotBusy[reqSlot];
  assign isDuplicate = fifoHit || inflightHit || loadedHit;

  assign fifoPush = req_valid_i && !fifoFull && !isDuplicate;
  assign fifoPop  = (state_q == PRQ_IDLE) && !fifoEmpty;

  // Simultaneous done+error and a silent timeout both resolve as a failed load.
  assign waitFail = (state_q == PRQ_WAIT) &&
                    (pr_error_i || (!pr_done_i && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1))));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= PRQ_IDLE;
      prReqValid_q   <= 1'b0;
      inflightSlot_q <= '0;
      inflightOu_q   <= '0;
      timer_q        <= '0;
      slotLoaded_q   <= '0;
      errSticky_q    <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slotOu_q[s] <= '0;
      end
    end else begin
      unique case (state_q)
        PRQ_IDLE: begin
          // The slot is unusable from the moment its rewrite is scheduled.
          if (!fifoEmpty) begin
            inflightSlot_q          <= headSlot;
            inflightOu_q            <= headOu;
            slotLoaded_q[headSlot]  <= 1'b0;
            prReqValid_q            <= 1'b1;
            state_q                 <= PRQ_REQ;
          end
        end
        PRQ_REQ: begin
          if (pr_req_ready_i) begin
            prReqValid_q <= 1'b0;
            timer_q      <= '0;
            state_q      <= PRQ_WAIT;
          end
        end
        PRQ_WAIT: begin
          if (waitFail) begin
            slotLoaded_q[inflightSlot_q] <= 1'b0;
            state_q                      <= PRQ_IDLE;
          end else if (pr_done_i) begin
            slotLoaded_q[inflightSlot_q] <= 1'b1;
            slotOu_q[inflightSlot_q]     <= inflightOu_q;
            state_q                      <= PRQ_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          prReqValid_q <= 1'b0;
          state_q      <= PRQ_IDLE;
        end
      endcase

      if (waitFail) begin
        errSticky_q <= 1'b1;
      end else if (err_clear_i) begin
        errSticky_q <= 1'b0;
      end
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot_ou
    assign slot_ou_o[s*OU_W +: OU_W] = slotOu_q[s];
  end

  assign req_ready_o    = !fifoFull;
  assign pr_req_valid_o = prReqValid_q;
  assign pr_grid_slot_o = inflightSlot_q;
  assign pr_ou_id_o     = inflightOu_q;
  assign slot_busy_o    = slotBusy;
  assign slot_loaded_o  = slotLoaded_q;
  assign queue_empty_o  = fifoEmpty && (state_q == PRQ_IDLE);
  assign err_sticky_o   = errSticky_q;

endmodule

// File: tb/tb_pr_request_queue.sv
// Directed scenarios followed by random traffic, all checked against a
// queue-based transaction model of the request queue.
module tb_pr_request_queue;
  import pr_request_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int SLOTS = 8;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic [4:0]  reqBus;
  logic        prReqValid;
  logic        prReqReady;
  logic [2:0]  prGridSlot;
  logic [1:0]  prOuId;
  logic        prDone;
  logic        prError;
  logic [7:0]  slotBusy;
  logic [7:0]  slotLoaded;
  logic [15:0] slotOu;
  logic        queueEmpty;
  logic        errSticky;
  logic        errClear;

  int vectors = 0;
  int miscompares = 0;
  int reqSeen = 0;

  // Model: pending requests, the one being loaded, and what each slot holds.
  pr_queue_inputs_t mq[$];
  pr_queue_inputs_t mCur;
  int               mPhase;   // 0 nothing in flight, 1 offered to controller, 2 loading
  int               mTimer;
  bit               mErr;
  bit               mLoaded [SLOTS];
  logic [1:0]       mTab [SLOTS];

  always #5 clk = ~clk;

  pr_request_queue #(
    .QUEUE_DEPTH    (DEPTH),
    .NUM_SLOTS      (SLOTS),
    .NUM_OUS        (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (reqValid),
    .req_ready_o    (reqReady),
    .req_i          (reqBus),
    .pr_req_valid_o (prReqValid),
    .pr_req_ready_i (prReqReady),
    .pr_grid_slot_o (prGridSlot),
    .pr_ou_id_o     (prOuId),
    .pr_done_i      (prDone),
    .pr_error_i     (prError),
    .slot_busy_o    (slotBusy),
    .slot_loaded_o  (slotLoaded),
    .slot_ou_o      (slotOu),
    .queue_empty_o  (queueEmpty),
    .err_sticky_o   (errSticky),
    .err_clear_i    (errClear)
  );

  task automatic expectEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit mBusy(input int s);
    foreach (mq[i]) if (int'(mq[i].grid_slot) == s) return 1'b1;
    return (mPhase != 0) && (int'(mCur.grid_slot) == s);
  endfunction

  function automatic bit mDup(input pr_queue_inputs_t r);
    foreach (mq[i]) if (mq[i] == r) return 1'b1;
    if (mPhase != 0 && mCur == r) return 1'b1;
    return mLoaded[r.grid_slot] && (mTab[r.grid_slot] == r.ou_id) && !mBusy(int'(r.grid_slot));
  endfunction

  task automatic modelStep(input bit v, input pr_queue_inputs_t r, input bit rdy,
                           input bit done, input bit err, input bit clr, input bit rs);
    bit full, dup, fail;
    if (rs) begin
      mq.delete();
      mCur   = '0;
      mPhase = 0;
      mTimer = 0;
      mErr   = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        mLoaded[s] = 1'b0;
        mTab[s]    = 2'd0;
      end
      return;
    end
    full = (mq.size() == DEPTH);
    dup  = mDup(r);
    fail = (mPhase == 2) && (err || (!done && mTimer == TMO - 1));
    case (mPhase)
      0: if (mq.size() != 0) begin
        mCur = mq.pop_front();
        mLoaded[mCur.grid_slot] = 1'b0;
        mPhase = 1;
      end
      1: if (rdy) begin
        mPhase = 2;
        mTimer = 0;
      end
      default: begin
        if (fail) begin
          mLoaded[mCur.grid_slot] = 1'b0;
          mPhase = 0;
        end else if (done) begin
          mLoaded[mCur.grid_slot] = 1'b1;
          mTab[mCur.grid_slot]    = mCur.ou_id;
          mPhase = 0;
        end else begin
          mTimer++;
        end
      end
    endcase
    if (fail) mErr = 1'b1;
    else if (clr) mErr = 1'b0;
    if (v && !full && !dup) mq.push_back(r);
  endtask

  task automatic checkOutput();
    logic [7:0]  eBusy;
    logic [7:0]  eLoaded;
    logic [15:0] eOu;
    for (int s = 0; s < SLOTS; s++) begin
      eBusy[s]       = mBusy(s);
      eLoaded[s]     = mLoaded[s];
      eOu[s*2 +: 2]  = mTab[s];
    end
    if (prReqValid === 1'b1) reqSeen++;
    expectEq("req_ready", reqReady, mq.size() < DEPTH);
    expectEq("pr_req_valid", prReqValid, mPhase == 1);
    if (mPhase == 1) begin
      expectEq("pr_grid_slot", prGridSlot, mCur.grid_slot);
      expectEq("pr_ou_id", prOuId, mCur.ou_id);
    end
    expectEq("slot_busy", slotBusy, eBusy);
    expectEq("slot_loaded", slotLoaded, eLoaded);
    expectEq("slot_ou", slotOu, eOu);
    expectEq("queue_empty", queueEmpty, (mq.size() == 0) && (mPhase == 0));
    expectEq("err_sticky", errSticky, mErr);
  endtask

  task automatic applyStimulus(input bit v, input logic [2:0] s, input logic [1:0] ou,
                               input bit rdy, input bit done, input bit err,
                               input bit clr, input bit rs);
    pr_queue_inputs_t r;
    r.grid_slot = s;
    r.ou_id     = ou;
    reqValid    = v;
    reqBus      = r;
    prReqReady  = rdy;
    prDone      = done;
    prError     = err;
    errClear    = clr;
    rst         = rs;
    @(posedge clk);
    modelStep(v, r, rdy, done, err, clr, rs);
    #1;
    checkOutput();
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(1'b0, 3'd0, 2'd0, rdy, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [2:0] s, input logic [1:0] ou, input bit rdy);
    applyStimulus(1'b1, s, ou, rdy, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Waits (bounded) for the next controller request, checks it, then completes it.
  task automatic serveNext(input string tag, input logic [2:0] s, input logic [1:0] ou);
    for (int t = 0; t < 8 && prReqValid !== 1'b1; t++) idle(1'b0);
    expectEq({tag, " valid"}, prReqValid, 1'b1);
    expectEq({tag, " slot"}, prGridSlot, s);
    expectEq({tag, " ou"}, prOuId, ou);
    idle(1'b1);
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] orderSlot [5];
    logic [1:0] orderOu [5];

    // Reset state
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expectEq("rst queue_empty", queueEmpty, 1'b1);
    expectEq("rst pr_req_valid", prReqValid, 1'b0);
    expectEq("rst slot_loaded", slotLoaded, 8'h00);
    expectEq("rst err_sticky", errSticky, 1'b0);

    // Single request: N+2 latency, done loads the slot
    push(3'd3, 2'd2, 1'b1);
    expectEq("t1 valid N+1", prReqValid, 1'b0);
    idle(1'b1);
    expectEq("t1 valid N+2", prReqValid, 1'b1);
    expectEq("t1 slot", prGridSlot, 3'd3);
    expectEq("t1 ou", prOuId, 2'd2);
    idle(1'b1);
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expectEq("t1 loaded3", slotLoaded[3], 1'b1);
    expectEq("t1 ou3", slotOu[7:6], 2'd2);
    expectEq("t1 queue_empty", queueEmpty, 1'b1);

    // Duplicate suppression
    reqSeen = 0;
    push(3'd1, 2'd1, 1'b1);
    push(3'd1, 2'd1, 1'b1);
    idle(1'b1);
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(3'd1, 2'd1, 1'b1);
    for (int k = 0; k < 3; k++) idle(1'b1);
    expectEq("t2 request count", reqSeen, 1);
    expectEq("t2 queue_empty", queueEmpty, 1'b1);
    expectEq("t2 loaded1", slotLoaded[1], 1'b1);
    expectEq("t2 ou1", slotOu[3:2], 2'd1);

    // Fill while the controller stalls, then drain in order
    orderSlot = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    orderOu   = '{2'd0, 2'd2, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 5; k++) push(orderSlot[k], orderOu[k], 1'b0);
    expectEq("t3 req_ready full", reqReady, 1'b0);
    push(3'd6, 2'd1, 1'b0);
    expectEq("t3 req_ready still full", reqReady, 1'b0);
    for (int k = 0; k < 5; k++) serveNext($sformatf("t3 drain%0d", k), orderSlot[k], orderOu[k]);
    idle(1'b0);
    expectEq("t3 queue_empty", queueEmpty, 1'b1);

    // done+error together is an error; clear, then set-beats-clear
    push(3'd6, 2'd3, 1'b1);
    idle(1'b1);
    idle(1'b1);
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expectEq("t4 loaded6", slotLoaded[6], 1'b0);
    expectEq("t4 err_sticky", errSticky, 1'b1);
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expectEq("t4 err cleared", errSticky, 1'b0);
    push(3'd6, 2'd3, 1'b1);
    idle(1'b1);
    idle(1'b1);
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expectEq("t4 set wins", errSticky, 1'b1);
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expectEq("t4 err cleared again", errSticky, 1'b0);

    // Timeout after exactly TMO cycles in WAIT; next entry then issues
    push(3'd2, 2'd1, 1'b1);
    push(3'd7, 2'd2, 1'b1);
    idle(1'b1);
    for (int k = 1; k < TMO; k++) begin
      idle(1'b0);
      expectEq($sformatf("t5 no abort w%0d", k + 1), errSticky, 1'b0);
    end
    idle(1'b0);
    expectEq("t5 abort err", errSticky, 1'b1);
    expectEq("t5 abort loaded2", slotLoaded[2], 1'b0);
    expectEq("t5 abort valid", prReqValid, 1'b0);
    idle(1'b0);
    expectEq("t5 next valid", prReqValid, 1'b1);
    expectEq("t5 next slot", prGridSlot, 3'd7);
    expectEq("t5 next ou", prOuId, 2'd2);
    idle(1'b1);
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset while loading with two entries still queued
    push(3'd0, 2'd1, 1'b1);
    push(3'd4, 2'd2, 1'b1);
    push(3'd5, 2'd3, 1'b1);
    expectEq("t6 pre-reset queue_empty", queueEmpty, 1'b0);
    applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expectEq("t6 queue_empty", queueEmpty, 1'b1);
    expectEq("t6 slot_loaded", slotLoaded, 8'h00);
    expectEq("t6 pr_req_valid", prReqValid, 1'b0);
    expectEq("t6 slot_ou", slotOu, 16'h0000);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
